lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the core's execute stage and the data-memory bus. Accepts one load or store per request handshake, aligns store data and byte enables, splits accesses that cross a 32-bit word boundary into two bus beats, then reassembles, shifts and sign/zero-extends load data. It returns one response per request and holds at most one bus transaction outstanding.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  core presents an access
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_f3  in  3  funct3 (core_pkg F3_BYTE, F3_HALFWORD, F3_WORD, F3_BYTE_U, F3_HALFWORD_U)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal f3 or bus error
- mem_req  out  1  bus request
- mem_gnt  in  1  request accepted this cycle
- mem_addr  out  32  word-aligned address (bits [1:0] = 0)
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_rvalid  in  1  beat complete (read data or write acknowledge)
- mem_rdata  in  32  read data
- mem_err  in  1  bus error, qualified by mem_rvalid

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid, latch all req_* fields.
  - Legal f3: go to REQ0.
  - Illegal f3 (3'b011, 3'b110, 3'b111): go to RESP with err=1. No bus activity.
- Size: 1, 2 or 4 bytes. off = addr[1:0]. mask = 4'b0001, 4'b0011 or 4'b1111.
  - m8 = {4'b0, mask} << off.
  - split = |m8[7:4].
- Beat 0: addr & ~3, be = m8[3:0].
- Beat 1: (addr & ~3) + 4, wrapping modulo 2^32; be = m8[7:4].
- Stores: w64 = {32'b0, wdata} << (8*off). Beat 0 drives w64[31:0]; beat 1 drives w64[63:32].
- REQ0/REQ1: mem_req = 1 with address, be, we and wdata held stable until mem_gnt, then go to WAIT0/WAIT1.
- WAIT0 on mem_rvalid: capture rdata0.
  - If mem_err: go to RESP with err=1. Beat 1 is skipped.
  - Else if split: go to REQ1.
  - Else: go to RESP.
- WAIT1 on mem_rvalid: capture rdata1, OR mem_err into err, go to RESP.
- Load data: r = ({rdata1, rdata0} >> (8*off))[31:0].
  - Byte: sign-extend r[7] for F3_BYTE; zero-extend for F3_BYTE_U.
  - Halfword: sign-extend r[15] for F3_HALFWORD; zero-extend for F3_HALFWORD_U.
  - Word: r unchanged.
- RESP: rsp_valid = 1 for one cycle, then go to IDLE.
- req_ready = (state == IDLE). A new request is accepted the cycle after RESP at the earliest.
- Reset at any point: state IDLE. Latched fields, err, rdata0 and rdata1 are cleared.
  - Any bus response in flight is not tracked; the memory side is reset by the same rst_n.
- mem_rvalid or mem_gnt outside the WAITx or REQx states is ignored.

## Timing
- Reset values (first cycle after rst_n sampled low):
  - req_ready = 1
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0
- All bus outputs are registered or decoded from registered state only. There is no combinational path from mem_* inputs to mem_* outputs.
- mem_rvalid arrives no earlier than the cycle after mem_gnt.
- Aligned access, zero-wait bus:
  - cycle 0: accept
  - cycle 1: mem_req and mem_gnt
  - cycle 2: mem_rvalid
  - cycle 3: rsp_valid
  - Latency is 3 cycles.
- Split access adds 2 cycles, giving 5.
- Illegal f3: rsp_valid in cycle 1.
- Each gnt or rvalid stall cycle adds one cycle of latency.
- Outside REQx, mem_be = 0 and mem_we = 0.

## Structure
- core_pkg gains:
  - lsu_state_e enum for the six states
  - LSU_SIZE_B/H/W size constants
  - f3_legal() and f3_size() functions
- Existing F3_* constants are reused.
- Sub-module lsu_align (combinational):
  - Inputs: off, size, unsigned flag, wdata, rdata0, rdata1.
  - Outputs: be0, be1, split, wd0, wd1, extended load result.
- lsu_ctrl holds the FSM and the capture registers only.

## Test plan
- SW 0xDEADBEEF to 0x100, zero-wait bus -> one beat: addr 0x100, be 4'hF, wdata 0xDEADBEEF; rsp_valid at cycle 3, err 0.
- LB from 0x103 with mem_rdata 0x80FFFFFF -> be 4'h8, rsp_rdata 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH 0x1234 to 0x203 (split):
  - beat 0: 0x200, be 4'h8, wdata 0x34000000
  - beat 1: 0x204, be 4'h1, wdata 0x00000012
  - rsp at cycle 5
- LW from 0x00000FFE with beats 0xAABBxxxx then 0xxxxxCCDD -> rsp_rdata 0xCCDDAABB. LW from 0xFFFFFFFD -> beat 1 address wraps to 0x00000000.
- Stress and error cases:
  - mem_gnt withheld 4 cycles -> mem_req and address stable throughout.
  - mem_err on beat 0 of a split -> no beat 1, rsp_err 1.
  - f3 3'b011 -> no mem_req, rsp_err 1 at cycle 1.
- rst_n low while in WAIT1 -> next cycle IDLE, req_ready 1, mem_req 0, no rsp_valid. A stray mem_rvalid afterwards is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, load/store unit state and size helpers
package core_pkg;

    localparam logic [2:0] F3_BYTE       = 3'b000;
    localparam logic [2:0] F3_HALFWORD   = 3'b001;
    localparam logic [2:0] F3_WORD       = 3'b010;
    localparam logic [2:0] F3_BYTE_U     = 3'b100;
    localparam logic [2:0] F3_HALFWORD_U = 3'b101;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ0  = 3'd1,
        LSU_WAIT0 = 3'd2,
        LSU_REQ1  = 3'd3,
        LSU_WAIT1 = 3'd4,
        LSU_RESP  = 3'd5
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_BYTE, F3_HALFWORD, F3_WORD, F3_BYTE_U, F3_HALFWORD_U: f3_legal = 1'b1;
            default:                                                 f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_BYTE, F3_BYTE_U:         f3_size = LSU_SIZE_B;
            F3_HALFWORD, F3_HALFWORD_U: f3_size = LSU_SIZE_H;
            default:                    f3_size = LSU_SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane alignment of store data and extraction/extension of load data
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic        split,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] rdata
);

    logic [3:0]  mask;
    logic [7:0]  m8;
    logic [5:0]  sh;
    logic [63:0] w64;
    logic [63:0] r64;
    logic [31:0] r;

    always_comb begin
        case (size)
            LSU_SIZE_B: mask = 4'b0001;
            LSU_SIZE_H: mask = 4'b0011;
            default:    mask = 4'b1111;
        endcase
    end

    // Treat the two beats as one 64-bit window so a straddling access is a plain shift.
    assign sh    = {off, 3'b000};
    assign m8    = {4'b0000, mask} << off;
    assign be0   = m8[3:0];
    assign be1   = m8[7:4];
    assign split = |m8[7:4];

    assign w64 = {32'b0, wdata} << sh;
    assign wd0 = w64[31:0];
    assign wd1 = w64[63:32];

    assign r64 = {rdata1, rdata0} >> sh;
    assign r   = r64[31:0];

    always_comb begin
        case (size)
            LSU_SIZE_B: rdata = uns ? {24'b0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
            LSU_SIZE_H: rdata = uns ? {16'b0, r[15:0]} : {{16{r[15]}}, r[15:0]};
            default:    rdata = r;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: request latch, one- or two-beat bus FSM, response
module lsu_ctrl
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    lsu_state_e  state;
    lsu_state_e  state_nxt;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata0_q;
    logic [31:0] rdata1_q;

    logic [31:0] word_addr;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic        split;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] ld_data;

    assign word_addr = {addr_q[31:2], 2'b00};

    lsu_align u_align (
        .off    (addr_q[1:0]),
        .size   (f3_size(f3_q)),
        .uns    (f3_q[2]),
        .wdata  (wdata_q),
        .rdata0 (rdata0_q),
        .rdata1 (rdata1_q),
        .be0    (be0),
        .be1    (be1),
        .split  (split),
        .wd0    (wd0),
        .wd1    (wd1),
        .rdata  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: begin
                if (req_valid) begin
                    state_nxt = f3_legal(req_f3) ? LSU_REQ0 : LSU_RESP;
                end
            end
            LSU_REQ0: begin
                if (mem_gnt) begin
                    state_nxt = LSU_WAIT0;
                end
            end
            LSU_WAIT0: begin
                if (mem_rvalid) begin
                    if (mem_err) begin
                        state_nxt = LSU_RESP;
                    end else if (split) begin
                        state_nxt = LSU_REQ1;
                    end else begin
                        state_nxt = LSU_RESP;
                    end
                end
            end
            LSU_REQ1: begin
                if (mem_gnt) begin
                    state_nxt = LSU_WAIT1;
                end
            end
            LSU_WAIT1: begin
                if (mem_rvalid) begin
                    state_nxt = LSU_RESP;
                end
            end
            LSU_RESP: state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    // Request fields are captured once in IDLE and held for both beats and the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            err_q    <= 1'b0;
            rdata0_q <= 32'b0;
            rdata1_q <= 32'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        f3_q     <= req_f3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        err_q    <= ~f3_legal(req_f3);
                        rdata0_q <= 32'b0;
                        rdata1_q <= 32'b0;
                    end
                end
                LSU_WAIT0: begin
                    if (mem_rvalid) begin
                        rdata0_q <= mem_rdata;
                        err_q    <= mem_err;
                    end
                end
                LSU_WAIT1: begin
                    if (mem_rvalid) begin
                        rdata1_q <= mem_rdata;
                        err_q    <= err_q | mem_err;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'b0;
        rsp_err   = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = 32'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'b0;
        case (state)
            LSU_IDLE: req_ready = 1'b1;
            LSU_REQ0: begin
                mem_req   = 1'b1;
                mem_addr  = word_addr;
                mem_we    = we_q;
                mem_be    = be0;
                mem_wdata = wd0;
            end
            LSU_REQ1: begin
                mem_req   = 1'b1;
                mem_addr  = word_addr + 32'd4;
                mem_we    = we_q;
                mem_be    = be1;
                mem_wdata = wd1;
            end
            LSU_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (we_q || err_q) ? 32'b0 : ld_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a scripted bus responder
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } rsp_t;

    beat_t       exp_beats[$];
    rsp_t        exp_rsps[$];
    logic [31:0] rd_q[$];
    logic        er_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int gnt_cnt = 0;
    int stall_cnt = 0;
    int rv_allow = -1;
    logic rv_pend = 1'b0;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_f3     (req_f3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                             input logic [31:0] wd, input logic [31:0] rd, input logic er);
        beat_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd;
        exp_beats.push_back(b);
        rd_q.push_back(rd);
        er_q.push_back(er);
    endtask

    // Bus responder: grants after stall_cnt cycles, returns read data the cycle after grant.
    initial begin
        beat_t b;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0; mem_err = 1'b0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0; mem_err = 1'b0;
            if (rv_pend && rv_allow != 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'b0;
                mem_err    = (er_q.size() > 0) ? er_q.pop_front() : 1'b0;
                rv_pend    = 1'b0;
                if (rv_allow > 0) rv_allow--;
            end else if (mem_req && rst_n) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_beat", {31'b0, mem_req}, 32'd0);
                end else begin
                    b = exp_beats[0];
                    chk("beat_addr", mem_addr, b.addr);
                    chk("beat_be", {28'b0, mem_be}, {28'b0, b.be});
                    chk("beat_we", {31'b0, mem_we}, {31'b0, b.we});
                    if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                    end else begin
                        mem_gnt = 1'b1;
                        void'(exp_beats.pop_front());
                        rv_pend = 1'b1;
                        gnt_cnt++;
                    end
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_rsps.size() == 0) begin
                    chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
                end else begin
                    e = exp_rsps.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    chk("rsp_latency", cyc - e.t0, e.lat);
                end
                rsp_cnt++;
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                         input int elat);
        rsp_t e;
        int n0;
        @(negedge clk);
        n0 = rsp_cnt;
        e.rdata = erd; e.err = eerr; e.lat = elat; e.t0 = cyc;
        exp_rsps.push_back(e);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && rsp_cnt == n0; i++) @(negedge clk);
        if (rsp_cnt == n0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            exp_rsps.delete(); exp_beats.delete(); rd_q.delete(); er_q.delete();
        end
    endtask

    initial begin
        int g0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b000; req_addr = 32'b0; req_wdata = 32'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        push_beat(32'h0000_0100, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);

        push_beat(32'h0000_0100, 4'h8, 1'b0, 32'h0, 32'h80FF_FFFF, 1'b0);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
        push_beat(32'h0000_0100, 4'h8, 1'b0, 32'h0, 32'h80FF_FFFF, 1'b0);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h0000_0080, 1'b0, 3);

        push_beat(32'h0000_0200, 4'h8, 1'b1, 32'h3400_0000, 32'h0, 1'b0);
        push_beat(32'h0000_0204, 4'h1, 1'b1, 32'h0000_0012, 32'h0, 1'b0);
        issue(1'b1, 3'b001, 32'h0000_0203, 32'h0000_1234, 32'h0, 1'b0, 5);

        push_beat(32'h0000_0FFC, 4'hC, 1'b0, 32'h0, 32'hAABB_1111, 1'b0);
        push_beat(32'h0000_1000, 4'h3, 1'b0, 32'h0, 32'h2222_CCDD, 1'b0);
        issue(1'b0, 3'b010, 32'h0000_0FFE, 32'h0, 32'hCCDD_AABB, 1'b0, 5);

        push_beat(32'hFFFF_FFFC, 4'hE, 1'b0, 32'h0, 32'h4433_2211, 1'b0);
        push_beat(32'h0000_0000, 4'h1, 1'b0, 32'h0, 32'h8877_6655, 1'b0);
        issue(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 32'h5544_3322, 1'b0, 5);

        push_beat(32'h0000_0000, 4'hC, 1'b0, 32'h0, 32'h8001_5555, 1'b0);
        issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'hFFFF_8001, 1'b0, 3);
        push_beat(32'h0000_0000, 4'hC, 1'b0, 32'h0, 32'h8001_5555, 1'b0);
        issue(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h0000_8001, 1'b0, 3);

        stall_cnt = 4;
        push_beat(32'h0000_0204, 4'hF, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h0000_0204, 32'h0BAD_F00D, 32'h0, 1'b0, 7);

        push_beat(32'h0000_0100, 4'hE, 1'b0, 32'h0, 32'h1234_5678, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 3);

        push_beat(32'h0000_0FFC, 4'hC, 1'b0, 32'h0, 32'hAABB_1111, 1'b0);
        push_beat(32'h0000_1000, 4'h3, 1'b0, 32'h0, 32'h2222_CCDD, 1'b1);
        issue(1'b0, 3'b010, 32'h0000_0FFE, 32'h0, 32'h0, 1'b1, 5);

        g0 = gnt_cnt;
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 1);
        chk("illegal_no_grant", gnt_cnt, g0);

        // Reset while the second beat of a split load is outstanding.
        rv_allow = 1;
        push_beat(32'h0000_0FFC, 4'hC, 1'b0, 32'h0, 32'hAABB_1111, 1'b0);
        push_beat(32'h0000_1000, 4'h3, 1'b0, 32'h0, 32'h2222_CCDD, 1'b0);
        g0 = gnt_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h0000_0FFE;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && gnt_cnt != g0 + 2; i++) @(negedge clk);
        chk("wait1_reached", gnt_cnt, g0 + 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("wr_req_ready", {31'b0, req_ready}, 32'd1);
        chk("wr_mem_req", {31'b0, mem_req}, 32'd0);
        chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        rv_allow = -1;
        rd_q.delete(); er_q.delete(); exp_beats.delete();
        rd_q.push_back(32'h1234_5678);
        er_q.push_back(1'b0);
        rv_pend = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
        end

        push_beat(32'h0000_0000, 4'h8, 1'b1, 32'hA500_0000, 32'h0, 1'b0);
        issue(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0, 1'b0, 3);

        repeat (3) @(negedge clk);
        chk("beats_left", exp_beats.size(), 32'd0);
        chk("rsps_left", exp_rsps.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
